weight_bank_loader: RTL and testbench

Writer side of the network's weight/bias bank: accepts a stream of 68 ten-bit fixed-point words over a valid/ready handshake and stores them in a register bank. Once loading completes, it presents the packed per-neuron weight vectors and biases that the four MAC neurons consume, and asserts `bank_valid`. It replaces the simulation-only file preload, so the network can be programmed in hardware. A registered read-back port lets software and benches verify the bank contents.

---
 rtl/nn_pkg.sv | 18 +
 rtl/weight_bank_regs.sv | 60 ++++++
 rtl/weight_bank_loader.sv | 119 +++++++++++
 tb/tb_weight_bank_loader.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants and types for the MAC network: word geometry, bank layout
// and the weight-loader state encoding.
package nn_pkg;

  localparam int WIDTH     = 10;
  localparam int N_IN      = 16;
  localparam int N_OUT     = 4;
  localparam int N_WORDS   = N_OUT * (N_IN + 1);
  localparam int BIAS_BASE = N_OUT * N_IN;
  localparam int ADDR_W    = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/weight_bank_regs.sv
// 68x10 weight/bias register file: one write port, the whole bank exposed
// combinationally, and a registered read-back port.
module weight_bank_regs
  import nn_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [WIDTH-1:0]           rd_data,
  output logic [N_WORDS*WIDTH-1:0]   bank_flat
);

  logic [WIDTH-1:0] mem_r [N_WORDS];
  logic [WIDTH-1:0] rd_word_s;
  logic [WIDTH-1:0] rd_data_r;

  // Bank storage: single write per cycle, cleared by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_WORDS; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en && (wr_addr < ADDR_W'(N_WORDS))) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read-back mux; addresses past the bank read as zero
  always_comb begin
    rd_word_s = '0;
    if (rd_addr < ADDR_W'(N_WORDS)) begin
      rd_word_s = mem_r[rd_addr];
    end else begin
      rd_word_s = '0;
    end
  end

  // Read-back register: samples the pre-write word, so same-cycle writes read old data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_r <= '0;
    end else begin
      rd_data_r <= rd_word_s;
    end
  end

  assign rd_data = rd_data_r;

  // Flatten the bank, word i at bits [i*WIDTH +: WIDTH]
  always_comb begin
    bank_flat = '0;
    for (int i = 0; i < N_WORDS; i++) begin
      bank_flat[i*WIDTH +: WIDTH] = mem_r[i];
    end
  end

endmodule

// File: rtl/weight_bank_loader.sv
// Streams 68 weight/bias words into the bank over valid/ready, then presents
// packed per-neuron weight vectors and biases with bank_valid.
module weight_bank_loader
  import nn_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic                    wr_valid,
  input  logic [WIDTH-1:0]        wr_data,
  output logic                    wr_ready,
  output logic                    bank_valid,
  output logic [N_IN*WIDTH-1:0]   ws3,
  output logic [N_IN*WIDTH-1:0]   ws2,
  output logic [N_IN*WIDTH-1:0]   ws1,
  output logic [N_IN*WIDTH-1:0]   ws0,
  output logic [WIDTH-1:0]        b3,
  output logic [WIDTH-1:0]        b2,
  output logic [WIDTH-1:0]        b1,
  output logic [WIDTH-1:0]        b0,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [WIDTH-1:0]        rd_data
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_WORDS - 1);

  loader_state_t              state_r;
  logic [ADDR_W-1:0]          cnt_r;
  logic                       wr_ready_r;
  logic                       bank_valid_r;
  logic                       wr_en_s;
  logic [N_WORDS*WIDTH-1:0]   bank_flat_s;
  logic [N_IN*WIDTH-1:0]      ws_s [N_OUT];
  logic [WIDTH-1:0]           b_s  [N_OUT];

  // A restart pulse takes priority, so a coincident word is never stored
  assign wr_en_s = wr_valid & wr_ready_r & ~load_start;

  // Loader FSM with registered wr_ready / bank_valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      wr_ready_r   <= 1'b0;
      bank_valid_r <= 1'b0;
    end else if (load_start) begin
      state_r      <= LOAD;
      cnt_r        <= '0;
      wr_ready_r   <= 1'b1;
      bank_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          wr_ready_r   <= 1'b0;
          bank_valid_r <= 1'b0;
        end
        LOAD: begin
          if (wr_valid && wr_ready_r) begin
            cnt_r <= cnt_r + 7'd1;
            if (cnt_r == LAST_IDX) begin
              state_r      <= DONE;
              wr_ready_r   <= 1'b0;
              bank_valid_r <= 1'b1;
            end
          end
        end
        DONE: begin
          wr_ready_r   <= 1'b0;
          bank_valid_r <= 1'b1;
        end
        default: begin
          state_r      <= IDLE;
          cnt_r        <= '0;
          wr_ready_r   <= 1'b0;
          bank_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ready   = wr_ready_r;
  assign bank_valid = bank_valid_r;

  weight_bank_regs u_regs (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en_s),
    .wr_addr   (cnt_r),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .bank_flat (bank_flat_s)
  );

  // Neuron n owns words [(3-n)*16 ..], lowest-index word in the MSBs
  always_comb begin
    for (int n = 0; n < N_OUT; n++) begin
      ws_s[n] = '0;
      b_s[n]  = '0;
    end
    for (int n = 0; n < N_OUT; n++) begin
      for (int j = 0; j < N_IN; j++) begin
        ws_s[n][(N_IN-1-j)*WIDTH +: WIDTH] =
          bank_flat_s[((N_OUT-1-n)*N_IN + j)*WIDTH +: WIDTH];
      end
      b_s[n] = bank_flat_s[(BIAS_BASE + N_OUT - 1 - n)*WIDTH +: WIDTH];
    end
  end

  assign ws3 = ws_s[3];
  assign ws2 = ws_s[2];
  assign ws1 = ws_s[1];
  assign ws0 = ws_s[0];
  assign b3  = b_s[3];
  assign b2  = b_s[2];
  assign b1  = b_s[1];
  assign b0  = b_s[0];

endmodule

// File: tb/tb_weight_bank_loader.sv
// Directed/randomized bench for weight_bank_loader against a word-list model.
module tb_weight_bank_loader;
  logic         clk;
  logic         reset;
  logic         load_start;
  logic         wr_valid;
  logic [9:0]   wr_data;
  logic         wr_ready;
  logic         bank_valid;
  logic [159:0] ws3, ws2, ws1, ws0;
  logic [9:0]   b3, b2, b1, b0;
  logic [6:0]   rd_addr;
  logic [9:0]   rd_data;

  int vectors = 0;
  int miscompares = 0;

  // Model: the bank contents, whether a load is in progress, and how many words it has taken
  logic [9:0] m_bank [68];
  bit         m_loading;
  bit         m_valid;
  int         m_taken;
  logic [9:0] exp_rd;

  weight_bank_loader dut (
    .clk(clk), .reset(reset), .load_start(load_start), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready), .bank_valid(bank_valid),
    .ws3(ws3), .ws2(ws2), .ws1(ws1), .ws0(ws0),
    .b3(b3), .b2(b2), .b1(b1), .b0(b0),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] pack(input int neuron);
    logic [159:0] r;
    r = 160'd0;
    for (int j = 0; j < 16; j++) r = (r << 10) | 160'(m_bank[(3 - neuron) * 16 + j]);
    return r;
  endfunction

  task automatic check_outputs();
    chk("wr_ready", 160'(wr_ready), 160'(m_loading));
    chk("bank_valid", 160'(bank_valid), 160'(m_valid));
    chk("rd_data", 160'(rd_data), 160'(exp_rd));
    chk("ws3", ws3, pack(3));
    chk("ws2", ws2, pack(2));
    chk("ws1", ws1, pack(1));
    chk("ws0", ws0, pack(0));
    chk("b3", 160'(b3), 160'(m_bank[64]));
    chk("b2", 160'(b2), 160'(m_bank[65]));
    chk("b1", 160'(b1), 160'(m_bank[66]));
    chk("b0", 160'(b0), 160'(m_bank[67]));
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge
  task automatic cycle(input logic ls, input logic v, input logic [9:0] d, input logic [6:0] ra);
    load_start = ls; wr_valid = v; wr_data = d; rd_addr = ra;
    @(posedge clk);
    exp_rd = (ra < 7'd68) ? m_bank[ra] : 10'd0;
    if (ls) begin
      m_loading = 1'b1; m_valid = 1'b0; m_taken = 0;
    end else if (m_loading && v) begin
      m_bank[m_taken] = d;
      m_taken++;
      if (m_taken == 68) begin m_loading = 1'b0; m_valid = 1'b1; end
    end
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [6:0] rnd_addr();
    return 7'($urandom_range(0, 127));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 68; i++) m_bank[i] = 10'd0;
    m_loading = 1'b0; m_valid = 1'b0; m_taken = 0; exp_rd = 10'd0;
  endtask

  initial begin
    logic [9:0] pat;
    logic [9:0] first;
    int         lat;
    int         iter;
    model_reset();
    reset = 1'b0; load_start = 1'b0; wr_valid = 1'b0; wr_data = 10'd0; rd_addr = 7'd0;
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b1;

    // Full load of bank[i] = i with wr_valid held high
    cycle(1'b1, 1'b0, 10'd0, rnd_addr());
    lat = 0;
    for (int i = 0; i < 68; i++) begin
      cycle(1'b0, 1'b1, 10'(i), rnd_addr());
      lat++;
      if (bank_valid) break;
    end
    chk("load_latency", 160'(lat), 160'd68);
    chk("ws3_msb", 160'(ws3[159:150]), 160'd0);
    chk("ws3_lsb", 160'(ws3[9:0]), 160'd15);
    chk("ws0_lsb", 160'(ws0[9:0]), 160'd63);
    chk("b0_val", 160'(b0), 160'd67);

    // Random wr_valid gaps with a fixed pattern
    pat = 10'b1110000111;
    cycle(1'b1, 1'b0, 10'd0, rnd_addr());
    iter = 0;
    while (!m_valid && iter < 2000) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), pat, rnd_addr());
      iter++;
    end
    chk("gap_done", 160'(bank_valid), 160'd1);
    chk("gap_ws2", ws2, {16{pat}});

    // Restart at word 30, then a full load of 0x155
    cycle(1'b1, 1'b0, 10'd0, rnd_addr());
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 10'($urandom), rnd_addr());
    cycle(1'b1, 1'b0, 10'd0, rnd_addr());
    for (int i = 0; i < 68; i++) cycle(1'b0, 1'b1, 10'h155, rnd_addr());
    chk("restart_valid", 160'(bank_valid), 160'd1);
    for (int a = 0; a < 68; a++) begin
      cycle(1'b0, 1'b0, 10'd0, 7'(a));
      chk("readback_155", 160'(rd_data), 160'h155);
    end

    // load_start coincident with a handshake carrying 0x3FF
    cycle(1'b1, 1'b0, 10'd0, rnd_addr());
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 10'($urandom), rnd_addr());
    cycle(1'b1, 1'b1, 10'h3FF, rnd_addr());
    first = 10'($urandom_range(0, 1022));
    cycle(1'b0, 1'b1, first, rnd_addr());
    chk("coincident_bank0", 160'(ws3[159:150]), 160'(first));
    for (int i = 1; i < 68; i++) cycle(1'b0, 1'b1, 10'($urandom), rnd_addr());

    // Writes in DONE are ignored
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 10'h2AA, rnd_addr());
      chk("done_ready", 160'(wr_ready), 160'd0);
    end
    chk("done_bank0", 160'(ws3[159:150]), 160'(first));

    // Asynchronous reset at word 40
    cycle(1'b1, 1'b0, 10'd0, rnd_addr());
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 10'($urandom), rnd_addr());
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 10'($urandom), rnd_addr());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
